// File: rtl/bus_rd_tracker.sv
// Read-transaction tracker: per-ID outstanding counters that throttle the AR channel
// and flag unexpected R lasts. Optional stall timer under BUS_RD_TRACKER_TIMEOUT_EN.
module bus_rd_tracker #(
  parameter  int AW          = 32,
  parameter  int IDW         = 4,
  parameter  int MAX_OUT     = 8,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int NID         = 2**IDW,
  localparam int CW          = $clog2(MAX_OUT + 1),
  localparam int OW          = $clog2(NID * MAX_OUT + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           ar_valid_i,
  output logic           ar_ready_o,
  input  logic [IDW-1:0] ar_id_i,
  input  logic [AW-1:0]  ar_addr_i,
  output logic           ar_valid_o,
  output logic [AW-1:0]  ar_addr_o,
  output logic [IDW-1:0] ar_id_o,
  input  logic           ar_ready_i,
  input  logic           r_valid_i,
  input  logic           r_ready_i,
  input  logic           r_last_i,
  input  logic [IDW-1:0] r_id_i,
  output logic [OW-1:0]  outstanding_o,
  output logic           err_unexp_o,
  output logic [IDW-1:0] err_id_o,
  output logic           timeout_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  if (MAX_OUT < 1 || MAX_OUT > 255 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("bus_rd_tracker: MAX_OUT must be 1..255 and TIMEOUT_CYC >= 1");
  end

  logic [CW-1:0]  cnt_q [NID];
  logic [OW-1:0]  total_q;
  logic [NID-1:0] inc_vec;
  logic [NID-1:0] dec_vec;
  logic           blk;
  logic           accept;
  logic           r_last_hs;
  logic           r_cnt_zero;
  logic           retire;
  logic           unexp;

  // Blocking is decided on the current count only; a same-cycle retire does not open a slot.
  assign blk        = (cnt_q[ar_id_i] == MAX_CNT);
  assign ar_valid_o = ar_valid_i & ~blk;
  assign ar_ready_o = ar_ready_i & ~blk;
  assign ar_addr_o  = ar_addr_i;
  assign ar_id_o    = ar_id_i;

  assign accept     = ar_valid_o & ar_ready_i;
  assign r_last_hs  = r_valid_i & r_ready_i & r_last_i;
  assign r_cnt_zero = (cnt_q[r_id_i] == '0);
  assign retire     = r_last_hs & ~r_cnt_zero;
  assign unexp      = r_last_hs & r_cnt_zero;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (accept) inc_vec[ar_id_i] = 1'b1;
    if (retire) dec_vec[r_id_i]  = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NID; i++) cnt_q[i] <= '0;
      total_q <= '0;
    end else begin
      for (int i = 0; i < NID; i++) begin
        if (inc_vec[i] && !dec_vec[i])      cnt_q[i] <= cnt_q[i] + CW'(1);
        else if (dec_vec[i] && !inc_vec[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
      end
      if (accept && !retire)      total_q <= total_q + OW'(1);
      else if (retire && !accept) total_q <= total_q - OW'(1);
    end
  end

  assign outstanding_o = total_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_unexp_o <= 1'b0;
      err_id_o    <= '0;
    end else begin
      err_unexp_o <= unexp;
      if (unexp) err_id_o <= r_id_i;
    end
  end

`ifdef BUS_RD_TRACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] timer_q;
  logic          timeout_q;
  logic          stalled;

  // The timer counts edges with reads pending and no retire; it saturates at the limit.
  assign stalled = (total_q != '0) && !retire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!stalled)                       timer_q <= '0;
      else if (timer_q != TW'(TIMEOUT_CYC)) timer_q <= timer_q + TW'(1);
      if (stalled && (timer_q == TW'(TIMEOUT_CYC - 1))) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rd_tracker.sv
// Randomized and directed bench for bus_rd_tracker against a count-per-ID reference model.
module tb_bus_rd_tracker;
  localparam int AW = 32, IDW = 4, MAX_OUT = 8, TOC = 16, NID = 16, OW = 8;
`ifdef BUS_RD_TRACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           ar_valid_i = 1'b0, ar_ready_i = 1'b0;
  logic           ar_ready_o, ar_valid_o;
  logic [IDW-1:0] ar_id_i = '0, ar_id_o, r_id_i = '0, err_id_o;
  logic [AW-1:0]  ar_addr_i = '0, ar_addr_o;
  logic           r_valid_i = 1'b0, r_ready_i = 1'b0, r_last_i = 1'b0;
  logic [OW-1:0]  outstanding_o;
  logic           err_unexp_o, timeout_o;

  bus_rd_tracker #(.AW(AW), .IDW(IDW), .MAX_OUT(MAX_OUT), .TIMEOUT_CYC(TOC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_valid_o(ar_valid_o), .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o), .ar_ready_i(ar_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_id_i(r_id_i),
    .outstanding_o(outstanding_o), .err_unexp_o(err_unexp_o), .err_id_o(err_id_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: reads in flight per ID, last error, stall length.
  int             m_cnt [NID];
  bit             m_err;
  logic [IDW-1:0] m_err_id;
  int             m_stall;
  bit             m_to;

  function automatic int m_total();
    int s = 0;
    for (int i = 0; i < NID; i++) s += m_cnt[i];
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NID; i++) m_cnt[i] = 0;
    m_err = 0; m_err_id = '0; m_stall = 0; m_to = 0;
  endfunction

  task automatic apply(input bit av, input logic [IDW-1:0] aid, input logic [AW-1:0] addr,
                       input bit ardy, input bit rv, input bit rr, input bit rl,
                       input logic [IDW-1:0] rid);
    ar_valid_i = av; ar_id_i = aid; ar_addr_i = addr; ar_ready_i = ardy;
    r_valid_i = rv; r_ready_i = rr; r_last_i = rl; r_id_i = rid;
    #1;
  endtask

  task automatic idle();
    apply(0, '0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic tick();
    bit acc, rl, unx, ret;
    int tot;
    tot = m_total();
    acc = ar_valid_i && ar_ready_i && (m_cnt[ar_id_i] < MAX_OUT);
    rl  = r_valid_i && r_ready_i && r_last_i;
    unx = rl && (m_cnt[r_id_i] == 0);
    ret = rl && !unx;
    if (ret) m_cnt[r_id_i]--;
    if (acc) m_cnt[ar_id_i]++;
    m_err = unx;
    if (unx) m_err_id = r_id_i;
    if (tot == 0 || ret) m_stall = 0;
    else begin
      m_stall++;
      if (TO_EN && m_stall >= TOC) m_to = 1;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    model_clear();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    apply(1, 4'd3, 32'h1000, 1, 0, 0, 0, '0);
    n_tests++; if (outstanding_o !== 8'd0) begin n_fail++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding_o); end
    n_tests++; if (err_unexp_o !== 1'b0) begin n_fail++; $display("FAIL rst_err_unexp got=%b exp=0", err_unexp_o); end
    n_tests++; if (err_id_o !== 4'd0) begin n_fail++; $display("FAIL rst_err_id got=%0d exp=0", err_id_o); end
    n_tests++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got=%b exp=0", timeout_o); end
    n_tests++; if ({ar_valid_o, ar_ready_o} !== 2'b11) begin n_fail++; $display("FAIL rst_ar_pass got=%b exp=11", {ar_valid_o, ar_ready_o}); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) begin apply(1, 4'd2, 32'h200 + i, 1, 0, 0, 0, '0); tick(); end
    idle();
    n_tests++; if (outstanding_o !== 8'd3) begin n_fail++; $display("FAIL basic_fill got=%0d exp=3", outstanding_o); end
    apply(0, '0, '0, 0, 1, 1, 0, 4'd2); tick();
    n_tests++; if (outstanding_o !== 8'd3) begin n_fail++; $display("FAIL basic_nonlast got=%0d exp=3", outstanding_o); end
    for (int i = 0; i < 3; i++) begin apply(0, '0, '0, 0, 1, 1, 1, 4'd2); tick(); end
    idle();
    n_tests++; if (outstanding_o !== 8'd0) begin n_fail++; $display("FAIL basic_drain got=%0d exp=0", outstanding_o); end
    n_tests++; if (err_unexp_o !== 1'b0) begin n_fail++; $display("FAIL basic_no_err got=%b exp=0", err_unexp_o); end
  endtask

  task automatic test_block();
    do_reset();
    for (int i = 0; i < MAX_OUT; i++) begin apply(1, 4'd5, 32'h500 + i, 1, 0, 0, 0, '0); tick(); end
    apply(1, 4'd5, 32'h5ff, 1, 0, 0, 0, '0);
    n_tests++; if ({ar_valid_o, ar_ready_o} !== 2'b00) begin n_fail++; $display("FAIL block_full got=%b exp=00", {ar_valid_o, ar_ready_o}); end
    tick();
    n_tests++; if (outstanding_o !== 8'd8) begin n_fail++; $display("FAIL block_no_accept got=%0d exp=8", outstanding_o); end
    apply(1, 4'd6, 32'h600, 1, 0, 0, 0, '0);
    n_tests++; if ({ar_valid_o, ar_ready_o} !== 2'b11) begin n_fail++; $display("FAIL block_other_id got=%b exp=11", {ar_valid_o, ar_ready_o}); end
    tick();
    n_tests++; if (outstanding_o !== 8'd9) begin n_fail++; $display("FAIL block_other_cnt got=%0d exp=9", outstanding_o); end
    apply(1, 4'd5, 32'h5fe, 1, 1, 1, 1, 4'd5);
    n_tests++; if ({ar_valid_o, ar_ready_o} !== 2'b00) begin n_fail++; $display("FAIL block_no_lookahead got=%b exp=00", {ar_valid_o, ar_ready_o}); end
    tick();
    n_tests++; if (outstanding_o !== 8'd8) begin n_fail++; $display("FAIL block_retire_only got=%0d exp=8", outstanding_o); end
    apply(1, 4'd5, 32'h5fd, 1, 0, 0, 0, '0);
    n_tests++; if ({ar_valid_o, ar_ready_o} !== 2'b11) begin n_fail++; $display("FAIL block_reopen got=%b exp=11", {ar_valid_o, ar_ready_o}); end
    idle();
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 4; i++) begin apply(1, 4'd1, 32'h100 + i, 1, 0, 0, 0, '0); tick(); end
    apply(1, 4'd1, 32'h1ff, 1, 1, 1, 1, 4'd1); tick();
    idle();
    n_tests++; if (outstanding_o !== 8'd4) begin n_fail++; $display("FAIL same_id_total got=%0d exp=4", outstanding_o); end
    apply(1, 4'd3, 32'h300, 1, 1, 1, 1, 4'd1); tick();
    idle();
    n_tests++; if (outstanding_o !== 8'd4) begin n_fail++; $display("FAIL diff_id_total got=%0d exp=4", outstanding_o); end
    for (int i = 0; i < 3; i++) begin apply(0, '0, '0, 0, 1, 1, 1, 4'd1); tick(); end
    apply(0, '0, '0, 0, 1, 1, 1, 4'd1); tick();
    idle();
    n_tests++; if ({err_unexp_o, err_id_o} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL same_id1_count got=%b/%0d exp=1/1", err_unexp_o, err_id_o); end
    n_tests++; if (outstanding_o !== 8'd1) begin n_fail++; $display("FAIL diff_id3_left got=%0d exp=1", outstanding_o); end
  endtask

  task automatic test_unexpected();
    do_reset();
    for (int i = 0; i < 2; i++) begin apply(1, 4'd2, 32'h20 + i, 1, 0, 0, 0, '0); tick(); end
    apply(0, '0, '0, 0, 1, 1, 1, 4'd9); tick();
    idle();
    n_tests++; if (err_unexp_o !== 1'b1) begin n_fail++; $display("FAIL unexp_pulse got=%b exp=1", err_unexp_o); end
    n_tests++; if (err_id_o !== 4'd9) begin n_fail++; $display("FAIL unexp_id got=%0d exp=9", err_id_o); end
    n_tests++; if (outstanding_o !== 8'd2) begin n_fail++; $display("FAIL unexp_total got=%0d exp=2", outstanding_o); end
    tick();
    n_tests++; if (err_unexp_o !== 1'b0) begin n_fail++; $display("FAIL unexp_one_cycle got=%b exp=0", err_unexp_o); end
    n_tests++; if (err_id_o !== 4'd9) begin n_fail++; $display("FAIL unexp_id_held got=%0d exp=9", err_id_o); end
    apply(0, '0, '0, 0, 1, 0, 1, 4'd11); tick();
    n_tests++; if (err_unexp_o !== 1'b0) begin n_fail++; $display("FAIL unexp_no_ready got=%b exp=0", err_unexp_o); end
    idle();
  endtask

  task automatic test_timeout();
    do_reset();
    apply(1, 4'd4, 32'h400, 1, 0, 0, 0, '0); tick();
    idle();
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_tests++; if (timeout_o !== (TO_EN && k >= TOC)) begin n_fail++; $display("FAIL timeout_stall k=%0d got=%b exp=%b", k, timeout_o, TO_EN && k >= TOC); end
    end
    apply(0, '0, '0, 0, 1, 1, 1, 4'd4); tick();
    idle();
    n_tests++; if (timeout_o !== TO_EN) begin n_fail++; $display("FAIL timeout_sticky got=%b exp=%b", timeout_o, TO_EN); end
    do_reset();
    apply(1, 4'd4, 32'h404, 1, 0, 0, 0, '0); tick();
    idle();
    for (int k = 1; k <= 14; k++) tick();
    apply(0, '0, '0, 0, 1, 1, 1, 4'd4); tick();
    idle();
    for (int k = 0; k < 6; k++) tick();
    n_tests++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL timeout_retired got=%b exp=0", timeout_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin apply(1, 4'd7, 32'h700 + i, 1, 0, 0, 0, '0); tick(); end
    apply(0, '0, '0, 0, 1, 1, 1, 4'd9); tick();
    idle();
    n_tests++; if ({outstanding_o, err_unexp_o} !== {8'd5, 1'b1}) begin n_fail++; $display("FAIL mid_pre got=%0d/%b exp=5/1", outstanding_o, err_unexp_o); end
    rst_ni = 1'b0;
    #1;
    n_tests++; if (outstanding_o !== 8'd0) begin n_fail++; $display("FAIL mid_async_total got=%0d exp=0", outstanding_o); end
    n_tests++; if ({err_unexp_o, err_id_o, timeout_o} !== 6'd0) begin n_fail++; $display("FAIL mid_async_err got=%b/%0d/%b exp=0/0/0", err_unexp_o, err_id_o, timeout_o); end
    model_clear();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    apply(0, '0, '0, 0, 1, 1, 1, 4'd7); tick();
    idle();
    n_tests++; if ({err_unexp_o, err_id_o, outstanding_o} !== {1'b1, 4'd7, 8'd0}) begin n_fail++; $display("FAIL mid_stale_r got=%b/%0d/%0d exp=1/7/0", err_unexp_o, err_id_o, outstanding_o); end
  endtask

  task automatic test_random();
    logic [IDW-1:0] aid, rid;
    logic [AW-1:0]  addr;
    bit             exp_blk;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      aid  = IDW'($urandom_range(0, 3));
      rid  = ($urandom_range(0, 9) == 0) ? IDW'($urandom_range(8, 15)) : IDW'($urandom_range(0, 3));
      addr = $urandom;
      apply($urandom_range(0, 3) != 0, aid, addr, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rid);
      exp_blk = (m_cnt[ar_id_i] >= MAX_OUT);
      n_tests++; if (ar_valid_o !== (ar_valid_i && !exp_blk)) begin n_fail++; $display("FAIL rnd_ar_valid c=%0d got=%b exp=%b", c, ar_valid_o, ar_valid_i && !exp_blk); end
      n_tests++; if (ar_ready_o !== (ar_ready_i && !exp_blk)) begin n_fail++; $display("FAIL rnd_ar_ready c=%0d got=%b exp=%b", c, ar_ready_o, ar_ready_i && !exp_blk); end
      n_tests++; if ({ar_addr_o, ar_id_o} !== {addr, aid}) begin n_fail++; $display("FAIL rnd_fwd c=%0d got=%h/%0d exp=%h/%0d", c, ar_addr_o, ar_id_o, addr, aid); end
      tick();
      n_tests++; if (outstanding_o !== OW'(m_total())) begin n_fail++; $display("FAIL rnd_total c=%0d got=%0d exp=%0d", c, outstanding_o, m_total()); end
      n_tests++; if ({err_unexp_o, err_id_o} !== {m_err, m_err_id}) begin n_fail++; $display("FAIL rnd_err c=%0d got=%b/%0d exp=%b/%0d", c, err_unexp_o, err_id_o, m_err, m_err_id); end
      n_tests++; if (timeout_o !== m_to) begin n_fail++; $display("FAIL rnd_timeout c=%0d got=%b exp=%b", c, timeout_o, m_to); end
    end
    idle();
  endtask

  initial begin
    model_clear();
    #2;
    test_reset();
    test_basic();
    test_block();
    test_same_cycle();
    test_unexpected();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_rd_tracker.md
BUS_RD_TRACKER -- requirements
Module: bus_rd_tracker

Interface
REQ-001 SHALL provide parameter AW, default 32, read address width in bits.
REQ-002 SHALL provide parameter IDW, default 4, transaction ID width in bits; NID = 2**IDW IDs.
REQ-003 SHALL provide parameter MAX_OUT, default 8, maximum outstanding reads per ID (1..255).
REQ-004 SHALL provide parameter TIMEOUT_CYC, default 1024, stall limit in cycles; used only under BUS_RD_TRACKER_TIMEOUT_EN.
REQ-005 SHALL provide port clk_i  input  1  single clock, all state on rising edge.
REQ-006 SHALL provide port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL provide port ar_valid_i  input  1  upstream read-address valid.
REQ-008 SHALL provide port ar_ready_o  output  1  upstream read-address ready.
REQ-009 SHALL provide port ar_id_i  input  IDW  read-address ID.
REQ-010 SHALL provide port ar_addr_i  input  AW  read address, forwarded unchanged on ar_addr_o.
REQ-011 SHALL provide port ar_valid_o / ar_addr_o / ar_id_o  output  1/AW/IDW  downstream read-address channel.
REQ-012 SHALL provide port ar_ready_i  input  1  downstream read-address ready.
REQ-013 SHALL provide port r_valid_i, r_ready_i, r_last_i  input  1 each  observed read-data handshake; the tracker does not drive the R channel.
REQ-014 SHALL provide port r_id_i  input  IDW  read-data ID.
REQ-015 SHALL provide port outstanding_o  output  $clog2(NID*MAX_OUT+1)  total outstanding reads.
REQ-016 SHALL provide port err_unexp_o  output  1  one-cycle pulse on R last for an ID with zero outstanding.
REQ-017 SHALL provide port err_id_o  output  IDW  ID of the most recent unexpected R last.
REQ-018 SHALL provide port timeout_o  output  1  sticky timeout flag (tied 0 without the macro).

Function
REQ-019 SHALL keep one counter per ID, width $clog2(MAX_OUT+1), plus a total counter.
REQ-020 SHALL compute blk = (cnt[ar_id_i] == MAX_OUT); ar_valid_o = ar_valid_i & ~blk; ar_ready_o = ar_ready_i & ~blk; combinational, zero latency.
REQ-021 SHALL count an AR accept when ar_valid_o & ar_ready_i; cnt[ar_id_i] and total increment at the next edge.
REQ-022 SHALL count an R retire when r_valid_i & r_ready_i & r_last_i and cnt[r_id_i] > 0; that count and total decrement.
REQ-023 SHALL, on accept and retire for the same ID in the same cycle, leave that count unchanged; for different IDs, each updates independently and total is unchanged.
REQ-024 SHALL, on an R last whose ID count is 0, leave counts unchanged, pulse err_unexp_o for one cycle starting the next edge, and register err_id_o.
REQ-025 SHALL never overflow: blk prevents accept at MAX_OUT, including when a same-cycle retire on that ID would free a slot (no look-ahead).
REQ-026 SHALL ignore R beats with r_last_i = 0.

Reset
REQ-027 SHALL, while rst_ni = 0, clear all counters, outstanding_o = 0, err_unexp_o = 0, err_id_o = 0, timeout_o = 0, with the timer cleared, asynchronously.
REQ-028 SHALL, on reset mid-operation, discard all outstanding state; subsequent R lasts for pre-reset reads are reported as unexpected.
REQ-029 SHALL release reset synchronously to clk_i; ar_valid_o/ar_ready_o follow REQ-020 with all counts 0.

Configuration
REQ-030 SHALL compile a stall timer when BUS_RD_TRACKER_TIMEOUT_EN is defined: $clog2(TIMEOUT_CYC+1) bits, cleared on any retire or when total = 0, else incremented per cycle; on reaching TIMEOUT_CYC it sets timeout_o, which stays set until reset.
REQ-031 SHALL, without BUS_RD_TRACKER_TIMEOUT_EN, contain no timer logic and tie timeout_o to 0.

Verification
REQ-032 SHALL cover: 3 ARs on ID 2, ar_ready_i = 1 -> outstanding_o = 3, then 3 R lasts on ID 2 -> 0.
REQ-033 SHALL cover: MAX_OUT = 8, 8 ARs on ID 5 -> ninth AR sees ar_ready_o = 0 and ar_valid_o = 0; ID 6 is still accepted.
REQ-034 SHALL cover: same-cycle AR accept and R last on ID 1 with count 4 -> count stays 4, total unchanged.
REQ-035 SHALL cover: R last on ID 9 with count 0 -> err_unexp_o high exactly 1 cycle, err_id_o = 9, outstanding_o unchanged.
REQ-036 SHALL cover: with the macro and TIMEOUT_CYC = 16, 1 AR with no R -> timeout_o = 1 at cycle 16 after accept and sticky; with an R last at cycle 15 -> timeout_o = 0.
REQ-037 SHALL cover: rst_ni asserted with 5 outstanding -> outputs zero immediately, with no clock edge required.
